// File: rtl/reset_seq_pkg.sv
// Shared definitions for the multi-channel reset sequencer: state encodings,
// fault counter width and a width helper.
package reset_seq_pkg;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  typedef enum logic [1:0] {
    StAssert  = ST_ASSERT,
    StQualify = ST_QUALIFY,
    StRelease = ST_RELEASE,
    StRun     = ST_RUN
  } seq_state_e;

  localparam int unsigned FAULT_CNT_W = 8;

  // Ceiling log2; callers pass values >= 2 so the result is never zero.
  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/reset_cond_sync.sv
// N-bit multi-stage flop synchroniser with a per-bit reset value, used for
// every asynchronous qualifier of the reset sequencer.
module reset_cond_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer_mc.sv
// Multi-channel fabric reset sequencer: qualifies synchronised conditions for a
// stability window, then releases NUM_CH reset domains in order, RELEASE_GAP apart.
module reset_sequencer_mc
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned NUM_PLL       = 1,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned RELEASE_GAP   = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EXT_RST_N,
  input  logic [NUM_PLL-1:0]     PLL_LOCK,
  input  logic                   INIT_DONE,
  input  logic                   SS_BUSY,
  input  logic                   FF_US_RESTORE,
  input  logic                   SW_RST_REQ,
  output logic [NUM_CH-1:0]      FABRIC_RESET_N,
  output logic                   SEQ_DONE,
  output logic [FAULT_CNT_W-1:0] FAULT_CNT
);

  localparam int unsigned MaxSg  = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
  localparam int unsigned MaxCnt = (MaxSg > NUM_CH) ? MaxSg : NUM_CH;
  localparam int unsigned CntW   = clog2_fn(MaxCnt + 1);
  localparam int unsigned SyncW  = NUM_PLL + 4;

  logic [SyncW-1:0] sync_in, sync_out;
  logic             ext_s, init_s, busy_s, frz_s, ok;
  logic [NUM_PLL-1:0] pll_s;

  seq_state_e state_q, state_d;
  logic [CntW-1:0] stab_q, stab_d, gap_q, gap_d, ch_q, ch_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic done_q, done_d;
  logic [FAULT_CNT_W-1:0] fault_q, fault_d;

  assign sync_in = {FF_US_RESTORE, SS_BUSY, INIT_DONE, PLL_LOCK, EXT_RST_N};

  reset_cond_sync #(
    .WIDTH   (SyncW),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_cond_sync (
    .clk (CLK),
    .rst (RST),
    .d   (sync_in),
    .q   (sync_out)
  );

  assign ext_s  = sync_out[0];
  assign pll_s  = sync_out[NUM_PLL:1];
  assign init_s = sync_out[NUM_PLL+1];
  assign busy_s = sync_out[NUM_PLL+2];
  assign frz_s  = sync_out[NUM_PLL+3];
  assign ok     = ext_s & (&pll_s) & init_s & ~busy_s;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    fault_d = fault_q;
    // Freeze is a plain hold: nothing below is evaluated, so a request pulse is lost.
    if (!frz_s) begin
      if (!ok || SW_RST_REQ) begin
        state_d = StAssert;
        stab_d  = '0;
        gap_d   = '0;
        ch_d    = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
        if (state_q == StRun && !ok && fault_q != '1) fault_d = fault_q + FAULT_CNT_W'(1);
      end else begin
        case (state_q)
          StAssert: begin
            state_d = StQualify;
            stab_d  = '0;
          end
          StQualify: begin
            if (stab_q == CntW'(STABLE_CYCLES - 1)) begin
              state_d = StRelease;
              ch_d    = '0;
              gap_d   = '0;
            end else begin
              stab_d = stab_q + CntW'(1);
            end
          end
          StRelease: begin
            if (gap_q == '0) begin
              rst_n_d = rst_n_q | (NUM_CH'(1) << ch_q);
              if (ch_q == CntW'(NUM_CH - 1)) begin
                done_d  = 1'b1;
                state_d = StRun;
              end else begin
                ch_d  = ch_q + CntW'(1);
                gap_d = CntW'(RELEASE_GAP - 1);
              end
            end else begin
              gap_d = gap_q - CntW'(1);
            end
          end
          StRun:   ;
          default: state_d = StAssert;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StAssert;
      stab_q  <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign FABRIC_RESET_N = rst_n_q;
  assign SEQ_DONE       = done_q;
  assign FAULT_CNT      = fault_q;

endmodule

// File: tb/tb_reset_sequencer_mc.sv
// Self-checking bench for reset_sequencer_mc: directed scenarios plus random
// stimulus against a model that tracks elapsed good cycles since the last assert.
module tb_reset_sequencer_mc;

  localparam int NCH = 4;
  localparam int NPLL = 2;
  localparam int S = 16;
  localparam int G = 4;
  localparam int SY = 2;
  localparam int BASE = S + 2;
  localparam int RUN_E = BASE + (NCH - 1) * G;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EXT_RST_N = 1'b0;
  logic [NPLL-1:0] PLL_LOCK = '0;
  logic INIT_DONE = 1'b0;
  logic SS_BUSY = 1'b0;
  logic FF_US_RESTORE = 1'b0;
  logic SW_RST_REQ = 1'b0;
  logic [NCH-1:0] FABRIC_RESET_N;
  logic SEQ_DONE;
  logic [7:0] FAULT_CNT;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: e = good, unfrozen edges since the last forced assert.
  int e = 0;
  int fault_m = 0;
  logic ok_h [SY];
  logic frz_h [SY];

  reset_sequencer_mc #(
    .NUM_CH        (NCH),
    .NUM_PLL       (NPLL),
    .STABLE_CYCLES (S),
    .RELEASE_GAP   (G),
    .SYNC_STAGES   (SY)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .EXT_RST_N      (EXT_RST_N),
    .PLL_LOCK       (PLL_LOCK),
    .INIT_DONE      (INIT_DONE),
    .SS_BUSY        (SS_BUSY),
    .FF_US_RESTORE  (FF_US_RESTORE),
    .SW_RST_REQ     (SW_RST_REQ),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .SEQ_DONE       (SEQ_DONE),
    .FAULT_CNT      (FAULT_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [NCH-1:0] exp_fab();
    logic [NCH-1:0] v;
    int n;
    v = '0;
    n = (e < BASE) ? 0 : ((e - BASE) / G + 1);
    for (int i = 0; i < NCH; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_done();
    return (e >= RUN_E);
  endfunction

  // Advance one clock edge, updating the model with the inputs seen at that edge.
  task automatic tick();
    logic raw_ok, ok_s, frz_s;
    raw_ok = EXT_RST_N & (&PLL_LOCK) & INIT_DONE & ~SS_BUSY;
    if (RST) begin
      e = 0;
      fault_m = 0;
      for (int i = 0; i < SY; i++) begin
        ok_h[i] = 1'b0;
        frz_h[i] = 1'b0;
      end
    end else begin
      ok_s = ok_h[SY-1];
      frz_s = frz_h[SY-1];
      if (!frz_s) begin
        if (!ok_s || SW_RST_REQ) begin
          if (!ok_s && e >= RUN_E && fault_m < 255) fault_m++;
          e = 0;
        end else if (e < 100000) begin
          e++;
        end
      end
      for (int i = SY - 1; i > 0; i--) begin
        ok_h[i] = ok_h[i-1];
        frz_h[i] = frz_h[i-1];
      end
      ok_h[0] = raw_ok;
      frz_h[0] = FF_US_RESTORE;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_good();
    EXT_RST_N = 1'b1;
    PLL_LOCK = '1;
    INIT_DONE = 1'b1;
    SS_BUSY = 1'b0;
    FF_US_RESTORE = 1'b0;
    SW_RST_REQ = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    set_good();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (FABRIC_RESET_N !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fab got=%b want=0000", FABRIC_RESET_N);
    end
    checks++;
    if (SEQ_DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b want=0", SEQ_DONE);
    end
    checks++;
    if (FAULT_CNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_fault got=%0d want=0", FAULT_CNT);
    end
  endtask

  task automatic test_power_up();
    int rise [NCH];
    int done_at;
    set_good();
    do_reset();
    for (int k = 0; k < NCH; k++) rise[k] = -1;
    done_at = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      checks++;
      if (FABRIC_RESET_N !== exp_fab() || SEQ_DONE !== exp_done() || FAULT_CNT !== 8'(fault_m)) begin
        errors++;
        $display("FAIL power_up n=%0d fab=%b want=%b done=%b want=%b", n, FABRIC_RESET_N,
                 exp_fab(), SEQ_DONE, exp_done());
      end
      for (int k = 0; k < NCH; k++) if (FABRIC_RESET_N[k] === 1'b1 && rise[k] < 0) rise[k] = n;
      if (SEQ_DONE === 1'b1 && done_at < 0) done_at = n;
    end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (rise[k] != 19 + 4 * k) begin
        errors++;
        $display("FAIL power_up_rise bit%0d got=%0d want=%0d", k, rise[k], 19 + 4 * k);
      end
    end
    checks++;
    if (done_at != 31) begin
      errors++;
      $display("FAIL power_up_done got=%0d want=31", done_at);
    end
  endtask

  task automatic test_qualify_glitch();
    int rise0;
    set_good();
    do_reset();
    rise0 = -1;
    for (int n = 0; n < 46; n++) begin
      PLL_LOCK[1] = (n == 10) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (FABRIC_RESET_N !== exp_fab() || SEQ_DONE !== exp_done() || FAULT_CNT !== 8'(fault_m)) begin
        errors++;
        $display("FAIL glitch n=%0d fab=%b want=%b fault=%0d want=%0d", n, FABRIC_RESET_N,
                 exp_fab(), FAULT_CNT, fault_m);
      end
      if (FABRIC_RESET_N[0] === 1'b1 && rise0 < 0) rise0 = n;
    end
    PLL_LOCK = '1;
    checks++;
    if (rise0 != 30) begin
      errors++;
      $display("FAIL glitch_rise0 got=%0d want=30", rise0);
    end
    checks++;
    if (FAULT_CNT !== 8'd0) begin
      errors++;
      $display("FAIL glitch_fault got=%0d want=0", FAULT_CNT);
    end
  endtask

  task automatic test_run_loss();
    int f0;
    int n;
    n = 0;
    while (SEQ_DONE !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (SEQ_DONE !== 1'b1) begin
      errors++;
      $display("FAIL run_loss_reach_run got=%b want=1", SEQ_DONE);
    end
    f0 = fault_m;
    PLL_LOCK[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (FABRIC_RESET_N !== 4'b1111) begin
      errors++;
      $display("FAIL run_loss_early got=%b want=1111", FABRIC_RESET_N);
    end
    tick();
    checks++;
    if (FABRIC_RESET_N !== 4'b0000 || SEQ_DONE !== 1'b0 || FAULT_CNT !== 8'(f0 + 1)) begin
      errors++;
      $display("FAIL run_loss_drop fab=%b done=%b fault=%0d want 0000 0 %0d", FABRIC_RESET_N,
               SEQ_DONE, FAULT_CNT, f0 + 1);
    end
    PLL_LOCK = '1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (FABRIC_RESET_N !== exp_fab() || SEQ_DONE !== exp_done() || FAULT_CNT !== 8'(fault_m)) begin
        errors++;
        $display("FAIL run_loss_reseq i=%0d fab=%b want=%b", i, FABRIC_RESET_N, exp_fab());
      end
    end
    checks++;
    if (SEQ_DONE !== 1'b1 || FAULT_CNT !== 8'(f0 + 1)) begin
      errors++;
      $display("FAIL run_loss_final done=%b fault=%0d want 1 %0d", SEQ_DONE, FAULT_CNT, f0 + 1);
    end
  endtask

  task automatic wait_two_released(input string name);
    int n;
    n = 0;
    while (FABRIC_RESET_N !== 4'b0011 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (FABRIC_RESET_N !== 4'b0011) begin
      errors++;
      $display("FAIL %s_reach got=%b want=0011", name, FABRIC_RESET_N);
    end
  endtask

  task automatic test_sw_mid_release();
    int pf;
    int rise0;
    set_good();
    do_reset();
    wait_two_released("sw_req");
    pf = fault_m;
    SW_RST_REQ = 1'b1;
    tick();
    SW_RST_REQ = 1'b0;
    checks++;
    if (FABRIC_RESET_N !== 4'b0000 || SEQ_DONE !== 1'b0 || FAULT_CNT !== 8'(pf)) begin
      errors++;
      $display("FAIL sw_req_drop fab=%b done=%b fault=%0d want 0000 0 %0d", FABRIC_RESET_N,
               SEQ_DONE, FAULT_CNT, pf);
    end
    rise0 = -1;
    for (int n = 1; n <= 40 && rise0 < 0; n++) begin
      tick();
      if (FABRIC_RESET_N[0] === 1'b1) rise0 = n;
    end
    checks++;
    if (rise0 != S + 2) begin
      errors++;
      $display("FAIL sw_req_rerelease got=%0d want=%0d", rise0, S + 2);
    end
  endtask

  task automatic test_freeze();
    int pf;
    int rise2;
    set_good();
    do_reset();
    wait_two_released("freeze");
    pf = fault_m;
    FF_US_RESTORE = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      SS_BUSY = (i >= 2 && i < 6) ? 1'b1 : 1'b0;
      if (i == 4) SW_RST_REQ = 1'b1;
      tick();
      SW_RST_REQ = 1'b0;
      checks++;
      if (FABRIC_RESET_N !== 4'b0011 || SEQ_DONE !== 1'b0 || FAULT_CNT !== 8'(pf)) begin
        errors++;
        $display("FAIL freeze_hold i=%0d fab=%b want=0011 fault=%0d want=%0d", i,
                 FABRIC_RESET_N, FAULT_CNT, pf);
      end
    end
    FF_US_RESTORE = 1'b0;
    rise2 = -1;
    for (int n = 0; n < 20 && rise2 < 0; n++) begin
      tick();
      checks++;
      if (FABRIC_RESET_N !== exp_fab()) begin
        errors++;
        $display("FAIL freeze_resume n=%0d fab=%b want=%b", n, FABRIC_RESET_N, exp_fab());
      end
      if (FABRIC_RESET_N[2] === 1'b1) rise2 = n;
    end
    checks++;
    if (rise2 != 3) begin
      errors++;
      $display("FAIL freeze_bit2 got=%0d want=3", rise2);
    end
  endtask

  task automatic test_saturation();
    int n;
    set_good();
    for (int it = 0; it < 300; it++) begin
      n = 0;
      while (SEQ_DONE !== 1'b1 && n < 60) begin
        tick();
        n++;
      end
      EXT_RST_N = 1'b0;
      tick();
      EXT_RST_N = 1'b1;
      tick();
      tick();
      tick();
    end
    checks++;
    if (FAULT_CNT !== 8'd255 || fault_m != 255) begin
      errors++;
      $display("FAIL sat_fault got=%0d want=255 model=%0d", FAULT_CNT, fault_m);
    end
    wait_two_released("sat_rst");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (FABRIC_RESET_N !== 4'b0000 || SEQ_DONE !== 1'b0 || FAULT_CNT !== 8'd0) begin
      errors++;
      $display("FAIL sat_rst fab=%b done=%b fault=%0d want 0000 0 0", FABRIC_RESET_N,
               SEQ_DONE, FAULT_CNT);
    end
  endtask

  task automatic test_random();
    set_good();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      EXT_RST_N = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < NPLL; p++) PLL_LOCK[p] = ($urandom_range(0, 299) != 0);
      INIT_DONE = ($urandom_range(0, 249) != 0);
      SS_BUSY = ($urandom_range(0, 199) == 0);
      SW_RST_REQ = ($urandom_range(0, 149) == 0);
      if (FF_US_RESTORE) FF_US_RESTORE = ($urandom_range(0, 7) != 0);
      else FF_US_RESTORE = ($urandom_range(0, 119) == 0);
      RST = ($urandom_range(0, 999) == 0);
      tick();
      checks++;
      if (FABRIC_RESET_N !== exp_fab() || SEQ_DONE !== exp_done() || FAULT_CNT !== 8'(fault_m)) begin
        errors++;
        $display("FAIL random i=%0d fab=%b want=%b done=%b want=%b fault=%0d want=%0d", i,
                 FABRIC_RESET_N, exp_fab(), SEQ_DONE, exp_done(), FAULT_CNT, fault_m);
      end
    end
    RST = 1'b0;
    set_good();
  endtask

  initial begin
    for (int i = 0; i < SY; i++) begin
      ok_h[i] = 1'b0;
      frz_h[i] = 1'b0;
    end
    test_reset();
    test_power_up();
    test_qualify_glitch();
    test_run_loss();
    test_sw_mid_release();
    test_freeze();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
